// File: rtl/btn_pkg.sv
// Shared defaults and elaboration helpers for the push-button conditioner.
package btn_pkg;

  localparam int unsigned DEF_CLK_HZ    = 100_000_000;
  localparam int unsigned DEF_SAMPLE_HZ = 1_000;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned sample_hz);
    return clk_hz / sample_hz;
  endfunction

  function automatic int unsigned div_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  // Hold counter must hold the larger of the two thresholds; never narrower than 1 bit.
  function automatic int unsigned hold_cnt_width(input int unsigned hold, input int unsigned rep);
    int unsigned m;
    m = (hold > rep) ? hold : rep;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled hysteresis filter,
// registered press/release edges and long-press / auto-repeat pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned     CNT_W     = hold_cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(HOLD_TICKS - REPEAT_TICKS);
  localparam bit              LONG_EN   = (HOLD_TICKS != 0);
  localparam bit              REPEAT_EN = (REPEAT_TICKS != 0);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] shift_q, shift_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    if (tick_i) begin
      shift_d = {shift_q[DEPTH-2:0], sync_q[1]};
      if (&shift_d) begin
        level_d = 1'b1;
      end else if (~|shift_d) begin
        level_d = 1'b0;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Counter restarts on every press edge; once at HOLD_C with no repeat it stays frozen.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    long_d  = 1'b0;
    if (!level_d || !level_q) begin
      cnt_d = '0;
    end else if (tick_i && LONG_EN && (cnt_q != HOLD_C)) begin
      if (cnt_inc == HOLD_C) begin
        long_d = 1'b1;
        cnt_d  = REPEAT_EN ? RELOAD_C : cnt_inc;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      shift_q   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      shift_q   <= shift_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: one shared sample-tick divider
// feeding N_BTN independent debounce channels.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned SAMPLE_HZ    = DEF_SAMPLE_HZ,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);

  localparam int unsigned      DIV      = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int unsigned      DIV_W    = div_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if (DIV < 2 || (CLK_HZ % SAMPLE_HZ) != 0) begin : g_bad_div
    $error("btn_debounce_multi: CLK_HZ/SAMPLE_HZ must be integral and >= 2");
  end
  if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
    $error("btn_debounce_multi: DEPTH must be in 2..32");
  end
  // The repeat reload value HOLD_TICKS-REPEAT_TICKS must not go negative.
  if (HOLD_TICKS != 0 && REPEAT_TICKS > HOLD_TICKS) begin : g_bad_repeat
    $error("btn_debounce_multi: REPEAT_TICKS must not exceed HOLD_TICKS");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEPTH       (DEPTH),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .btn_i    (i_btn[gi]),
      .level_o  (o_level[gi]),
      .press_o  (o_press[gi]),
      .release_o(o_release[gi]),
      .long_o   (o_long[gi])
    );
  end

endmodule
